// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder slice processes the operands LSB-first,
// one bit per clock, behind a start/done handshake.
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_s_q, sh_s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_sum, fa_cout;

  // The single full-adder slice shared by every bit position.
  always_comb begin
    fa_sum  = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
    fa_cout = (sh_a_q[0] & sh_b_q[0]) | (carry_q & (sh_a_q[0] ^ sh_b_q[0]));
  end

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          sh_s_d  = '0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sh_s_d  = {fa_sum, sh_s_q[WIDTH-1:1]};
        sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (cnt_q == CntLast) begin
          // Result is published only here, so sum/cout never expose partial bits.
          sum_d   = {fa_sum, sh_s_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: the driver queues hand-computed results and the
// cycle in which done must rise; a monitor pops and compares on every done pulse.
module tb_serial_add_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  typedef struct {
    logic [W:0] res;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [W:0] hold = '0;
  bit         sim_end = 1'b0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive operands at a falling edge; done must rise W+1 cycles later.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W:0] exp_res);
    exp_t e;
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    e.res = exp_res;
    e.cyc = cyc + W + 1;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W:0] exp_res);
    @(negedge clk);
    issue(ia, ib, ic, exp_res);
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_after_accept", 32'(busy), 32'd1);
    repeat (W + 1) @(negedge clk);
  endtask

  // Monitor: pops on every done pulse; between pulses the result must not move.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sim_end) break;
      if (!rst_n) begin
        hold = '0;
      end else if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 32'({cout, sum}), 32'(e.res));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        hold = {cout, sum};
      end else begin
        chk("result_stable", 32'({cout, sum}), 32'(hold));
      end
    end
  end

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic adds, full carry ripple, all-ones with carry-in.
    do_op(8'h5A, 8'h3C, 1'b0, 9'h096);
    do_op(8'hFF, 8'h01, 1'b0, 9'h100);
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Start re-pulsed during RUN with new operands must be ignored.
    @(negedge clk);
    issue(8'h21, 8'h13, 1'b1, 9'h035);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h77;
    b     = 8'h11;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    do_op(8'h01, 8'h01, 1'b0, 9'h002);

    // Start held high: a new operation is accepted in every DONE cycle.
    @(negedge clk);
    issue(8'h12, 8'h34, 1'b0, 9'h046);
    repeat (W + 1) @(negedge clk);
    issue(8'h80, 8'h80, 1'b1, 9'h101);
    repeat (W + 1) @(negedge clk);
    issue(8'hAA, 8'h55, 1'b1, 9'h100);
    repeat (W + 1) @(negedge clk);
    issue(8'h0F, 8'hF0, 1'b0, 9'h0FF);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    chk("pending_results", 32'(sb.size()), 32'd0);
    sim_end = 1'b1;
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
